// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: word/address widths and FSM states.
package weight_loader_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  // Address width shared with the neuron weight memory read/write ports.
  localparam int unsigned ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/weight_loader.sv
// Writer side of the neuron weight memory: streams NUM_OF_WEIGHTS words into
// the memory at addresses 0..N-1, then captures the following word as bias.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned NUM_OF_WEIGHTS = 784,
  parameter int unsigned WORD_W         = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_add,
  output logic [WORD_W-1:0] w_data,
  output logic [WORD_W-1:0] bias_value,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(NUM_OF_WEIGHTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OF_WEIGHTS - 1);

  if (NUM_OF_WEIGHTS < 1) begin : g_bad_num_of_weights
    $error("weight_loader: NUM_OF_WEIGHTS must be >= 1");
  end

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              busy_n, done_n;
  logic [WORD_W-1:0] bias_n;
  logic              xfer;
  logic              wr_fire;

  // FSM, counter, status and bias registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bias_value <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      bias_value <= bias_n;
    end
  end

  // Next-state, handshake and write-request decode
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    busy_n   = busy;
    done_n   = done;
    bias_n   = bias_value;
    wr_fire  = 1'b0;
    in_ready = (state == LOAD_W) || (state == LOAD_B);
    xfer     = in_valid && in_ready;

    unique case (state)
      IDLE, DONE: begin
        // abort outranks start when both arrive outside a load
        if (start && !abort) begin
          state_n = LOAD_W;
          cnt_n   = '0;
          done_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      LOAD_W: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (xfer) begin
          wr_fire = 1'b1;
          // Counter parks on the last address instead of stepping past it,
          // so it never exceeds NUM_OF_WEIGHTS-1.
          if (cnt == LAST_CNT) begin
            state_n = LOAD_B;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (xfer) begin
          bias_n  = in_data;
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered memory write port; address and data hold between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      w_en   <= 1'b0;
      w_add  <= '0;
      w_data <= '0;
    end else begin
      w_en <= wr_fire;
      if (wr_fire) begin
        w_add  <= ADDR_W'(cnt);
        w_data <= in_data;
      end
    end
  end

endmodule
